data_check_16bit: RTL

- Receive-side checker for the 16-bit test-frame stream that the data source writes into the SSD write FIFO; sits on the FIFO read port (or on the SSD readback path).
- Frame format: 512 words per frame.
  - Word 0 = 16'h1ACF, word 1 = 16'hFC1D.
  - Word 2 = frame counter [31:16], word 3 = frame counter [15:0].
  - Word n = n for n = 4..511.
- Pops words, hunts for sync, checks header, counter continuity and payload, and exports lock status and error statistics.

---
 rtl/data_frame_pkg.sv | 27 ++
 rtl/data_check_16bit_if.sv | 15 +
 rtl/data_check_16bit_sat_cnt16.sv | 18 +
 rtl/data_check_16bit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/data_frame_pkg.sv
// Shared definitions for the 16-bit test-frame stream, used by both the
// data source that builds frames and the checker that verifies them.
//   FRAME_LEN    words per frame including the 4-word header
//   SYNC0/SYNC1  the two sync words that open every frame
//   IDX_*        header word offsets within a frame
//   chk_state_t  checker FSM states
package data_frame_pkg;

  localparam int          FRAME_LEN  = 512;
  localparam logic [15:0] SYNC0      = 16'h1ACF;
  localparam logic [15:0] SYNC1      = 16'hFC1D;

  localparam int IDX_SYNC0  = 0;
  localparam int IDX_SYNC1  = 1;
  localparam int IDX_CNT_HI = 2;
  localparam int IDX_CNT_LO = 3;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,   // searching for SYNC0, not locked
    SYNC2   = 3'd1,   // SYNC0 seen, expecting SYNC1
    CNT_HI  = 3'd2,   // frame counter bits [31:16]
    CNT_LO  = 3'd3,   // frame counter bits [15:0]
    PAYLOAD = 3'd4,   // words 4..FRAME_LEN-1, word n == n
    CHK0    = 3'd5    // locked, next word must be SYNC0
  } chk_state_t;

endpackage

// File: rtl/data_check_16bit_if.sv
// FIFO read-port bundle between the checker and the SSD write FIFO.
//   rdempty  FIFO empty flag            (FIFO -> checker)
//   q        read data, valid the cycle after rdreq (normal mode)
//   enable   pop enable, 0 stalls reading
//   rdreq    read request                (checker -> FIFO)
// master = checker side, slave = FIFO / environment side.
interface data_check_16bit_if;
  logic        rdempty;
  logic [15:0] q;
  logic        enable;
  logic        rdreq;

  modport master (input rdempty, input q, input enable, output rdreq);
  modport slave  (output rdempty, output q, output enable, input rdreq);
endinterface

// File: rtl/data_check_16bit_sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at 16'hFFFF.
//   clk  clock
//   clr  synchronous clear, wins over inc
//   inc  count one event this cycle
//   cnt  current count
module sat_cnt16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)                        cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/data_check_16bit.sv
// data_check_16bit: receive-side checker for the 16-bit test-frame stream.
// Pops words from a normal-mode FIFO, hunts for SYNC0/SYNC1, tracks the
// 32-bit frame counter, checks payload word n == n and keeps statistics.
//   clk          system clock
//   RST          synchronous reset, active high
//   fifo         FIFO read port (rdempty, q, enable in; rdreq out)
//   locked       frame sync acquired
//   frame_ok     frames received with zero errors (wraps)
//   payload_err  payload word mismatches (saturating)
//   seq_err      frame counter discontinuities (saturating)
//   lock_lost    lock-loss events (saturating)
//   err_pulse    one-cycle pulse, aligned with the counter update
module data_check_16bit #(
  parameter int          FRAME_LEN = data_frame_pkg::FRAME_LEN,
  parameter logic [15:0] SYNC0     = data_frame_pkg::SYNC0,
  parameter logic [15:0] SYNC1     = data_frame_pkg::SYNC1
) (
  input  logic                       clk,
  input  logic                       RST,
  data_check_16bit_if.master         fifo,
  output logic                       locked,
  output logic [31:0]                frame_ok,
  output logic [15:0]                payload_err,
  output logic [15:0]                seq_err,
  output logic [15:0]                lock_lost,
  output logic                       err_pulse
);
  import data_frame_pkg::*;

  localparam int                WIDX_W = $clog2(FRAME_LEN);
  localparam logic [WIDX_W-1:0] W_LAST = WIDX_W'(FRAME_LEN - 1);
  localparam logic [WIDX_W-1:0] W_S0   = WIDX_W'(IDX_SYNC0);
  localparam logic [WIDX_W-1:0] W_S1   = WIDX_W'(IDX_SYNC1);
  localparam logic [WIDX_W-1:0] W_HI   = WIDX_W'(IDX_CNT_HI);
  localparam logic [WIDX_W-1:0] W_LO   = WIDX_W'(IDX_CNT_LO);
  localparam logic [WIDX_W-1:0] W_PAY0 = WIDX_W'(IDX_CNT_LO + 1);

  chk_state_t        st;
  logic              vld;
  logic [WIDX_W-1:0] widx;
  logic [15:0]       hi;
  logic [31:0]       exp_cnt;
  logic              first_frame;
  logic              frame_bad;
  logic [31:0]       rx_cnt;
  logic              inc_pay, inc_seq, inc_lost, inc_ok;

  // Normal-mode FIFO: data for a request shows up on q one cycle later,
  // which is exactly when vld is high.
  assign fifo.rdreq = fifo.enable & ~fifo.rdempty;
  assign rx_cnt     = {hi, fifo.q};

  // Error decode for the word being consumed this cycle; counters and
  // err_pulse register it at the next edge.
  always_comb begin
    inc_pay  = 1'b0;
    inc_seq  = 1'b0;
    inc_lost = 1'b0;
    if (vld) begin
      case (st)
        CNT_LO:  inc_seq  = !first_frame && (rx_cnt != exp_cnt);
        PAYLOAD: inc_pay  = fifo.q != 16'(widx);
        CHK0:    inc_lost = fifo.q != SYNC0;
        // locked only while in SYNC2 when the SYNC0 came from CHK0
        SYNC2:   inc_lost = locked && (fifo.q != SYNC1);
        default: ;
      endcase
    end
    inc_ok = vld && (st == PAYLOAD) && (widx == W_LAST) && !frame_bad && !inc_pay;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      st          <= HUNT;
      vld         <= 1'b0;
      widx        <= '0;
      hi          <= '0;
      exp_cnt     <= '0;
      first_frame <= 1'b1;
      frame_bad   <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      frame_ok    <= '0;
    end else begin
      vld       <= fifo.rdreq;
      err_pulse <= inc_pay | inc_seq | inc_lost;
      if (inc_ok) frame_ok <= frame_ok + 32'd1;
      if (vld) begin
        case (st)
          HUNT: begin
            if (fifo.q == SYNC0) begin
              st   <= SYNC2;
              widx <= W_S1;
            end
          end
          SYNC2: begin
            if (fifo.q == SYNC1) begin
              st   <= CNT_HI;
              widx <= W_HI;
            end else if (fifo.q == SYNC0 && !locked) begin
              widx <= W_S1;               // repeated SYNC0 while hunting
            end else begin
              st   <= HUNT;
              widx <= W_S0;
              if (locked) begin
                locked      <= 1'b0;
                first_frame <= 1'b1;
              end
            end
          end
          CNT_HI: begin
            hi   <= fifo.q;
            st   <= CNT_LO;
            widx <= W_LO;
          end
          CNT_LO: begin
            // resync to whatever arrived so one jump costs one seq_err
            exp_cnt     <= rx_cnt + 32'd1;
            first_frame <= 1'b0;
            locked      <= 1'b1;
            frame_bad   <= inc_seq;
            st          <= PAYLOAD;
            widx        <= W_PAY0;
          end
          PAYLOAD: begin
            if (inc_pay) frame_bad <= 1'b1;
            if (widx == W_LAST) begin
              st   <= CHK0;
              widx <= W_S0;
            end else begin
              widx <= widx + 1'b1;
            end
          end
          CHK0: begin
            if (fifo.q == SYNC0) begin
              st   <= SYNC2;
              widx <= W_S1;
            end else begin
              st          <= HUNT;
              widx        <= W_S0;
              locked      <= 1'b0;
              first_frame <= 1'b1;
            end
          end
          default: st <= HUNT;
        endcase
      end
    end
  end

  sat_cnt16 u_pay  (.clk(clk), .clr(RST), .inc(inc_pay),  .cnt(payload_err));
  sat_cnt16 u_seq  (.clk(clk), .clr(RST), .inc(inc_seq),  .cnt(seq_err));
  sat_cnt16 u_lost (.clk(clk), .clr(RST), .inc(inc_lost), .cnt(lock_lost));

endmodule
